// File: rtl/cc_ctrl_pkg.sv
// Shared types for the condition-code update controller: ARM condition
// field encoding, flag bit positions and the software-write FSM states.
package cc_ctrl_pkg;

    typedef enum logic [3:0] {
        EQ = 4'h0,
        NE = 4'h1,
        CS = 4'h2,
        CC = 4'h3,
        MI = 4'h4,
        PL = 4'h5,
        VS = 4'h6,
        VC = 4'h7,
        HI = 4'h8,
        LS = 4'h9,
        GE = 4'hA,
        LT = 4'hB,
        GT = 4'hC,
        LE = 4'hD,
        AL = 4'hE,
        NV = 4'hF
    } cond_e;

    // Flag layout of the status register word
    localparam int Z_BIT = 3;
    localparam int C_BIT = 2;
    localparam int N_BIT = 1;
    localparam int V_BIT = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        WRITE = 2'd2,
        ACK   = 2'd3
    } msr_state_e;

endpackage

// File: rtl/cc_update_ctrl_cond_eval.sv
// Combinational ARM condition-field evaluator: flags {Z,C,N,V} + cond -> pass.
module cond_eval
    import cc_ctrl_pkg::*;
(
    input  logic [3:0] flags,
    input  logic [3:0] cond,
    output logic       pass
);

    logic z;
    logic c;
    logic n;
    logic v;

    assign z = flags[Z_BIT];
    assign c = flags[C_BIT];
    assign n = flags[N_BIT];
    assign v = flags[V_BIT];

    always_comb begin
        pass = 1'b0;
        case (cond_e'(cond))
            EQ:      pass = z;
            NE:      pass = !z;
            CS:      pass = c;
            CC:      pass = !c;
            MI:      pass = n;
            PL:      pass = !n;
            VS:      pass = v;
            VC:      pass = !v;
            HI:      pass = c && !z;
            LS:      pass = !c || z;
            GE:      pass = (n == v);
            LT:      pass = (n != v);
            GT:      pass = !z && (n == v);
            LE:      pass = z || (n != v);
            AL:      pass = 1'b1;
            // 1111 is reserved and never passes
            NV:      pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cc_update_ctrl.sv
// Condition-code update controller: ALU/MSR write arbitration, in-flight
// flag scoreboard, ID-stage condition evaluation and stall. Optional CC_FWD_EN.
module cc_update_ctrl
    import cc_ctrl_pkg::*;
#(
    parameter int MAX_INFLIGHT = 3,
    parameter int CNT_W        = 2
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic [3:0]       real_cc,
    input  logic             alu_s,
    input  logic [3:0]       alu_cc,
    input  logic             id_s_issue,
    input  logic             cond_valid,
    input  logic [3:0]       cond,
    input  logic             msr_req,
    input  logic [3:0]       msr_cc,
    output logic             cc_wr_en,
    output logic [3:0]       cc_wr_data,
    output logic             cond_true,
    output logic             stall,
    output logic             msr_ack,
    output logic [CNT_W-1:0] inflight,
    output logic             sb_err,
    output logic [1:0]       msr_state
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

    msr_state_e       state_q;
    msr_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             err_q;
    logic             err_d;

    logic             go_ok;
    logic             fwd_hit;
    logic             in_msr_write;
    logic             cond_stall;
    logic             full_stall;
    logic             fsm_stall;
    logic             issue_acc;
    logic [3:0]       eff_cc;

    // The MSR write may only land when no ALU flag result is still owed and
    // nothing new is issuing, so the software value is never overwritten by
    // an older instruction.
    assign go_ok = (cnt_q == '0) && !alu_s && !id_s_issue;

`ifdef CC_FWD_EN
    // Last outstanding writer retiring now: its flags are final this cycle.
    assign fwd_hit = (cnt_q == ONE_CNT) && alu_s && !id_s_issue;
    assign eff_cc  = fwd_hit ? alu_cc : real_cc;
`else
    assign fwd_hit = 1'b0;
    assign eff_cc  = real_cc;
`endif

    cond_eval u_cond_eval (
        .flags (eff_cc),
        .cond  (cond),
        .pass  (cond_true)
    );

    assign in_msr_write = (state_q == WRITE) || (state_q == ACK);

    // Stall sources: unsettled flags for a conditional, full scoreboard,
    // and issue while a software write is pending.
    assign cond_stall = cond_valid && (cond_e'(cond) != AL) &&
                        (((cnt_q != '0) && !fwd_hit) || in_msr_write);
    assign full_stall = id_s_issue && (cnt_q == MAX_CNT) && !alu_s;
    assign fsm_stall  = id_s_issue && (state_q != IDLE);
    assign stall      = cond_stall || full_stall || fsm_stall;
    assign issue_acc  = id_s_issue && !stall;

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (alu_s && (cnt_q == '0)) begin
            // Retire with nothing outstanding: hold at zero, flag it
            err_d = 1'b1;
        end else if (issue_acc && !alu_s) begin
            cnt_d = cnt_q + ONE_CNT;
        end else if (!issue_acc && alu_s) begin
            cnt_d = cnt_q - ONE_CNT;
        end
    end

    // msr_req is a level request held until msr_ack; msr_ack is a single-cycle
    // pulse issued the cycle after the write, and the request is only
    // re-sampled once the FSM is back in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (msr_req) state_d = go_ok ? WRITE : WAIT;
            WAIT:    if (go_ok) state_d = WRITE;
            WRITE:   state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // ALU has priority; a write during reset would race the register clear
    always_comb begin
        cc_wr_en   = 1'b0;
        cc_wr_data = '0;
        if (!CLR) begin
            if (alu_s) begin
                cc_wr_en   = 1'b1;
                cc_wr_data = alu_cc;
            end else if (state_q == WRITE) begin
                cc_wr_en   = 1'b1;
                cc_wr_data = msr_cc;
            end
        end
    end

    assign msr_ack   = !CLR && (state_q == ACK);
    assign inflight  = cnt_q;
    assign sb_err    = err_q;
    assign msr_state = state_q;

endmodule
